seg_msg_decoder: RTL and testbench

- Receive-side counterpart of the HappyNewYear2026 7-segment message generator.
- Samples the 8-bit segment bus the design drives on uo_out, waits for each pattern to settle, and decodes it back to a character code.
- Buffers decoded characters in a small FIFO and flags every occurrence of the sequence "2026".
- Used as an on-chip loopback checker and as the bench-side monitor.

---
 rtl/seg_msg_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg_msg_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_msg_decoder.sv
// Seven-segment bus decoder: settles each glyph, decodes it, queues the codes, and flags "2026".
// Define SEG_ACTIVE_LOW_EN for common-anode panels, where seg_in is inverted at the input.
module seg_msg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FIFO_AW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic       sample_en,
    input  logic       rd_en,
    output logic [4:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       char_valid,
    output logic [4:0] char_code,
    output logic       year_seen,
    output logic [7:0] year_count
);

    // state  | meaning
    // TRACK  | follow seg_in, count identical samples into cnt_q
    // ACCEPT | one cycle: emit char_code, push FIFO, update last-accepted

    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam int          DEPTH      = 1 << FIFO_AW;
    localparam logic [4:0]  CODE_BLANK = 5'h10;
    localparam logic [4:0]  CODE_UNK   = 5'h1F;
    localparam logic [19:0] HIST_CLEAR = {4{CODE_UNK}};
    localparam logic [19:0] YEAR_SEQ   = {5'd2, 5'd0, 5'd2, 5'd6};

    typedef enum logic {
        TRACK  = 1'b0,
        ACCEPT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [6:0] seg_pat;
    logic       unused_dp;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_pat = ~seg_in[6:0];
`else
    assign seg_pat = seg_in[6:0];
`endif
    assign unused_dp = seg_in[7];

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h76:   decode = 5'h0A;
            7'h77:   decode = 5'h0B;
            7'h73:   decode = 5'h0C;
            7'h6E:   decode = 5'h0D;
            7'h37:   decode = 5'h0E;
            7'h79:   decode = 5'h0F;
            7'h00:   decode = CODE_BLANK;
            default: decode = CODE_UNK;
        endcase
    endfunction

    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_q, last_eff;
    logic [4:0] code_q;

    // During ACCEPT the candidate is already the accepted glyph, so compare against it.
    always_comb begin
        state_d  = TRACK;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        last_eff = (state_q == ACCEPT) ? {1'b0, cand_q} : last_q;
        if (sample_en) begin
            if (seg_pat != cand_q) begin
                cand_d = seg_pat;
                cnt_d  = 8'd1;
            end else if (cnt_q != STABLE_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (cnt_d == STABLE_MAX && {1'b0, cand_d} != last_eff) begin
                state_d = ACCEPT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRACK;
            cand_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 8'hFF;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (state_q == ACCEPT) last_q <= {1'b0, cand_q};
            if (state_d == ACCEPT) code_q <= decode(cand_d);
        end
    end

    assign char_valid = (state_q == ACCEPT);
    assign char_code  = code_q;

    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [4:0]       mem [DEPTH];
    logic             push, pop, do_push;

    assign push    = char_valid;
    assign pop     = rd_en && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_push = push && (!full || pop);
    assign rd_data = empty ? 5'd0 : mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= code_q;
    end

    // History holds the last four non-blank codes, oldest in the top slot.
    logic [19:0] hist_q, hist_shift;

    assign hist_shift = {hist_q[14:0], code_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= HIST_CLEAR;
            year_seen  <= 1'b0;
            year_count <= '0;
        end else begin
            year_seen <= 1'b0;
            if (char_valid) begin
                if (code_q == CODE_UNK) begin
                    hist_q <= HIST_CLEAR;
                end else if (code_q != CODE_BLANK) begin
                    hist_q <= hist_shift;
                    if (hist_shift == YEAR_SEQ) begin
                        year_seen <= 1'b1;
                        if (year_count != 8'hFF) year_count <= year_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_msg_decoder.sv
// Scoreboard bench for seg_msg_decoder: stimulus queues expected codes, a monitor checks each char_valid.
module tb_seg_msg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic       sample_en;
    logic       rd_en;
    logic [4:0] rd_data;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       char_valid;
    logic [4:0] char_code;
    logic       year_seen;
    logic [7:0] year_count;

    always #5 clk = ~clk;

    seg_msg_decoder #(.STABLE_CYCLES(4), .FIFO_AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .sample_en  (sample_en),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .char_valid (char_valid),
        .char_code  (char_code),
        .year_seen  (year_seen),
        .year_count (year_count)
    );

    int         n_pass      = 0;
    int         n_total     = 0;
    int         year_pulses = 0;
    int         exp_years   = 0;
    logic [4:0] exp_q [$];
    logic [4:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] enc(input logic [7:0] p);
`ifdef SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (char_valid) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_char: got 0x%0h expected none", char_code);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("char_code", 32'(char_code), 32'(mon_exp));
                    end
                end
                if (year_seen) year_pulses++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seg_in    = enc(pat);
            sample_en = 1'b1;
        end
    endtask

    // Trailing idle cycles; rd_en is optionally raised in the cycle an accept would occupy.
    task automatic settle(input bit pop_acc);
        @(negedge clk);
        sample_en = 1'b0;
        rd_en     = pop_acc;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed(input logic [7:0] pat, input int n, input bit acc,
                        input logic [4:0] code, input bit pop_acc);
        if (acc) exp_q.push_back(code);
        drive(pat, n);
        settle(pop_acc);
    endtask

    task automatic pop_chk(input logic [4:0] exp);
        @(negedge clk);
        check("fifo_head", 32'(rd_data), 32'(exp));
        check("fifo_not_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b0;
        rd_en     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        seg_in    = 8'h00;
        sample_en = 1'b0;
        rd_en     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_empty",      32'(empty),      32'd1);
        check("rst_full",       32'(full),       32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_char_valid", 32'(char_valid), 32'd0);
        check("rst_year_count", 32'(year_count), 32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);
        rst = 1'b0;

        // Held glyph: one accept, the cycle after the fourth sample.
        exp_q.push_back(5'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) check("latency_early", 32'(char_valid), 32'd0);
            if (i == 4) check("latency_hit",   32'(char_valid), 32'd1);
            seg_in    = enc(8'h5B);
            sample_en = 1'b1;
        end
        settle(1'b0);
        check("held_rd_data", 32'(rd_data),   32'd2);
        check("held_empty",   32'(empty),     32'd0);
        check("held_code",    32'(char_code), 32'd2);
        pop_chk(5'd2);
        check("held_drained", 32'(empty), 32'd1);

        // 2 _ 0 _ 2 _ 6 with blanks (one blank and one 2 carry the dp bit).
        do_reset();
        exp_years++;
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b0);
        feed(8'h00, 4, 1'b1, 5'h10, 1'b0);
        feed(8'h3F, 4, 1'b1, 5'h00, 1'b0);
        feed(8'h80, 4, 1'b1, 5'h10, 1'b0);
        feed(8'hDB, 4, 1'b1, 5'h02, 1'b0);
        feed(8'h00, 4, 1'b1, 5'h10, 1'b0);
        feed(8'h7D, 4, 1'b1, 5'h06, 1'b0);
        check("year_pulses_1", 32'(year_pulses), 32'(exp_years));
        check("year_count_1",  32'(year_count),  32'd1);
        pop_chk(5'h02); pop_chk(5'h10); pop_chk(5'h00); pop_chk(5'h10);
        pop_chk(5'h02); pop_chk(5'h10); pop_chk(5'h06);
        check("year_drained", 32'(empty), 32'd1);

        // Glitch rejected; sample_en gaps hold the count.
        drive(8'h06, 2);
        feed(8'h07, 4, 1'b1, 5'h07, 1'b0);
        exp_q.push_back(5'h04);
        drive(8'h66, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seg_in    = enc(8'h49);
            sample_en = 1'b0;
        end
        drive(8'h66, 2);
        settle(1'b0);
        check("code_holds", 32'(char_code), 32'h04);
        pop_chk(5'h07);
        pop_chk(5'h04);
        check("glitch_drained", 32'(empty), 32'd1);

        // Fill, simultaneous push/pop at full, then overflow; unknown code clears history.
        do_reset();
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b1);
        check("rd_while_empty", 32'(empty),   32'd0);
        check("rd_while_head",  32'(rd_data), 32'd2);
        feed(8'h3F, 4, 1'b1, 5'h00, 1'b0);
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b0);
        feed(8'h49, 4, 1'b1, 5'h1F, 1'b0);
        feed(8'h7D, 4, 1'b1, 5'h06, 1'b0);
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b0);
        feed(8'h3F, 4, 1'b1, 5'h00, 1'b0);
        check("full_at_7", 32'(full), 32'd0);
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b0);
        check("full_at_8",     32'(full),     32'd1);
        check("no_ovf_at_8",   32'(overflow), 32'd0);
        check("head_at_8",     32'(rd_data),  32'd2);
        exp_years++;
        feed(8'h7D, 4, 1'b1, 5'h06, 1'b1);
        check("full_pushpop",    32'(full),        32'd1);
        check("no_ovf_pushpop",  32'(overflow),    32'd0);
        check("head_after_pop",  32'(rd_data),     32'd0);
        check("year_pulses_2",   32'(year_pulses), 32'(exp_years));
        check("year_count_unk",  32'(year_count),  32'd1);
        feed(8'h5B, 4, 1'b1, 5'h02, 1'b0);
        check("ovf_set",    32'(overflow), 32'd1);
        check("full_still", 32'(full),     32'd1);
        pop_chk(5'h00); pop_chk(5'h02); pop_chk(5'h1F); pop_chk(5'h06);
        pop_chk(5'h02); pop_chk(5'h00); pop_chk(5'h02); pop_chk(5'h06);
        check("ovf_drained", 32'(empty), 32'd1);
        check("ovf_sticky",  32'(overflow), 32'd1);

        // Reset while an accept is in flight.
        feed(8'h4F, 4, 1'b1, 5'h03, 1'b0);
        check("pre_rst_nonempty", 32'(empty), 32'd0);
        drive(8'h66, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_empty",      32'(empty),      32'd1);
        check("midrst_valid",      32'(char_valid), 32'd0);
        check("midrst_rd_data",    32'(rd_data),    32'd0);
        check("midrst_overflow",   32'(overflow),   32'd0);
        check("midrst_year_count", 32'(year_count), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        sample_en = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_empty", 32'(empty), 32'd1);

`ifdef SEG_ACTIVE_LOW_EN
        exp_q.push_back(5'h02);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seg_in    = 8'hA4;
            sample_en = 1'b1;
        end
        settle(1'b0);
        check("active_low_code", 32'(char_code), 32'h02);
`endif

        repeat (2) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
